// File: rtl/kt_pkg.sv
// Shared types and BCD helpers for the kitchen timer control block.
package kt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EDIT_MIN = 3'd1,
    ST_EDIT_SEC = 3'd2,
    ST_RUN      = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_ALARM    = 3'd5
  } kt_state_t;

  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_MIN  = 2'd1;
  localparam logic [1:0] EDIT_SEC  = 2'd2;

  localparam logic [7:0] MIN_MAX = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;

  // Two-digit BCD increment that wraps to 00 past the given limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'h9) begin
      r = {v[7:4] + 4'h1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

  // Two-digit BCD decrement; callers never pass 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'h0) begin
      r = {v[7:4] - 4'h1, 4'h9};
    end else begin
      r = {v[7:4], v[3:0] - 4'h1};
    end
    return r;
  endfunction

endpackage

// File: rtl/kt_bcd_time.sv
// MM:SS BCD time registers with increment, borrow-decrement and clear strobes.
module kt_bcd_time
  import kt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       dec,
  input  logic       clr,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       is_zero,
  output logic       is_last
);

  logic [7:0] min_r;
  logic [7:0] sec_r;

  // Time registers; dec is only issued while the time is non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_r <= 8'h00;
      sec_r <= 8'h00;
    end else if (clr) begin
      min_r <= 8'h00;
      sec_r <= 8'h00;
    end else if (dec) begin
      if (sec_r == 8'h00) begin
        sec_r <= SEC_MAX;
        min_r <= bcd_dec(min_r);
      end else begin
        sec_r <= bcd_dec(sec_r);
      end
    end else begin
      if (inc_min) begin
        min_r <= bcd_inc(min_r, MIN_MAX);
      end
      if (inc_sec) begin
        sec_r <= bcd_inc(sec_r, SEC_MAX);
      end
    end
  end

  assign min_bcd = min_r;
  assign sec_bcd = sec_r;
  assign is_zero = (min_r == 8'h00) && (sec_r == 8'h00);
  assign is_last = (min_r == 8'h00) && (sec_r == 8'h01);

endmodule

// File: rtl/kt_timer_ctrl.sv
// Kitchen timer control FSM: time entry, countdown, pause and alarm.
// Optional increment auto-repeat is built when KT_AUTOREPEAT_EN is defined.
module kt_timer_ctrl
  import kt_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int ALARM_SECS   = 30,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_down,
  input  logic       inc_down,
  input  logic       inc_state,
  input  logic       start_down,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] edit_sel,
  output logic       running,
  output logic       alarm
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int AW = $clog2(ALARM_SECS + 1);

  kt_state_t  state_r, state_nxt_s;
  logic [PW-1:0] presc_r;
  logic [AW-1:0] alarm_cnt_r;
  logic       tick_s, entry_s, rep_fire_s, inc_take_s;
  logic       inc_min_s, inc_sec_s, dec_s, clr_s;
  logic       is_zero_s, is_last_s;
  logic [1:0] edit_sel_nxt_s;
  logic [1:0] edit_sel_r;
  logic       running_r, alarm_r;

  assign tick_s  = (presc_r == PW'(CLK_HZ - 1));
  assign entry_s = ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_ALARM)) && (state_nxt_s != state_r);

  // Next-state and time-command decode; start > mode > inc priority.
  always_comb begin
    state_nxt_s = state_r;
    inc_min_s   = 1'b0;
    inc_sec_s   = 1'b0;
    dec_s       = 1'b0;
    clr_s       = 1'b0;
    inc_take_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_down) begin
          state_nxt_s = is_zero_s ? ST_IDLE : ST_RUN;
        end else if (mode_down) begin
          state_nxt_s = ST_EDIT_MIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EDIT_MIN, ST_EDIT_SEC: begin
        if (start_down) begin
          state_nxt_s = is_zero_s ? ST_IDLE : ST_RUN;
        end else if (mode_down) begin
          state_nxt_s = (state_r == ST_EDIT_MIN) ? ST_EDIT_SEC : ST_IDLE;
        end else if (inc_down || rep_fire_s) begin
          inc_take_s = inc_down;
          inc_min_s  = (state_r == ST_EDIT_MIN);
          inc_sec_s  = (state_r == ST_EDIT_SEC);
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (start_down) begin
          state_nxt_s = ST_PAUSE;
        end else if (tick_s) begin
          dec_s       = 1'b1;
          state_nxt_s = is_last_s ? ST_ALARM : ST_RUN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (start_down) begin
          state_nxt_s = ST_RUN;
        end else if (mode_down) begin
          state_nxt_s = ST_IDLE;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (start_down || mode_down || inc_down) begin
          state_nxt_s = ST_IDLE;
        end else if (tick_s && (alarm_cnt_r == AW'(ALARM_SECS - 1))) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ALARM;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Edit-digit select for the registered output.
  always_comb begin
    case (state_nxt_s)
      ST_EDIT_MIN: edit_sel_nxt_s = EDIT_MIN;
      ST_EDIT_SEC: edit_sel_nxt_s = EDIT_SEC;
      default:     edit_sel_nxt_s = EDIT_NONE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      edit_sel_r <= EDIT_NONE;
      running_r  <= 1'b0;
      alarm_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      edit_sel_r <= edit_sel_nxt_s;
      running_r  <= (state_nxt_s == ST_RUN);
      alarm_r    <= (state_nxt_s == ST_ALARM);
    end
  end

  // 1 Hz prescaler: restarts on RUN/ALARM entry so a resumed run waits a full second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (entry_s) begin
      presc_r <= '0;
    end else if ((state_r == ST_RUN) || (state_r == ST_ALARM)) begin
      presc_r <= tick_s ? '0 : presc_r + PW'(1);
    end
  end

  // Seconds spent sounding the alarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_cnt_r <= '0;
    end else if (entry_s) begin
      alarm_cnt_r <= '0;
    end else if ((state_r == ST_ALARM) && tick_s) begin
      alarm_cnt_r <= alarm_cnt_r + AW'(1);
    end
  end

`ifdef KT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_r;
  logic          rep_arm_r;
  logic          rep_first_r;

  assign rep_fire_s = rep_arm_r && inc_state &&
                      (rep_cnt_r == (rep_first_r ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));

  // Auto-repeat timer, armed by an accepted press and dropped on release or state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_r   <= '0;
      rep_arm_r   <= 1'b0;
      rep_first_r <= 1'b1;
    end else if (inc_take_s) begin
      rep_cnt_r   <= '0;
      rep_arm_r   <= 1'b1;
      rep_first_r <= 1'b1;
    end else if (!inc_state || (state_nxt_s != state_r)) begin
      rep_cnt_r   <= '0;
      rep_arm_r   <= 1'b0;
      rep_first_r <= 1'b1;
    end else if (rep_arm_r) begin
      if (rep_fire_s) begin
        rep_cnt_r   <= '0;
        rep_first_r <= 1'b0;
      end else begin
        rep_cnt_r <= rep_cnt_r + RW'(1);
      end
    end
  end
`else
  logic unused_inc_state_s;
  assign unused_inc_state_s = inc_state;
  assign rep_fire_s         = 1'b0;
`endif

  kt_bcd_time u_time (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_min (inc_min_s),
    .inc_sec (inc_sec_s),
    .dec     (dec_s),
    .clr     (clr_s),
    .min_bcd (min_bcd),
    .sec_bcd (sec_bcd),
    .is_zero (is_zero_s),
    .is_last (is_last_s)
  );

  assign edit_sel = edit_sel_r;
  assign running  = running_r;
  assign alarm    = alarm_r;

endmodule

// File: tb/tb_kt_timer_ctrl.sv
// Directed self-checking bench for kt_timer_ctrl (small CLK_HZ/ALARM/REPEAT values).
module tb_kt_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_down, inc_down, inc_state, start_down;
  logic [7:0] min_bcd, sec_bcd;
  logic [1:0] edit_sel;
  logic       running, alarm;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kt_timer_ctrl #(
    .CLK_HZ       (10),
    .ALARM_SECS   (3),
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_down  (mode_down),
    .inc_down   (inc_down),
    .inc_state  (inc_state),
    .start_down (start_down),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .edit_sel   (edit_sel),
    .running    (running),
    .alarm      (alarm)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, returning on the following falling edge.
  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic press(input logic m, input logic i, input logic s);
    mode_down  = m;
    inc_down   = i;
    start_down = s;
    wait_edges(1);
    mode_down  = 1'b0;
    inc_down   = 1'b0;
    start_down = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_edges(2);
    rst_n = 1'b1;
  endtask

  task automatic check_time(input string tag, input logic [7:0] m, input logic [7:0] s);
    check_eq({tag, "_min"}, {24'd0, min_bcd}, {24'd0, m});
    check_eq({tag, "_sec"}, {24'd0, sec_bcd}, {24'd0, s});
  endtask

  initial begin
    rst_n = 1'b0; mode_down = 1'b0; inc_down = 1'b0; inc_state = 1'b0; start_down = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state; start at 00:00 is ignored.
    check_time("rst", 8'h00, 8'h00);
    check_eq("rst_edit", {30'd0, edit_sel}, 32'd0);
    check_eq("rst_run", {31'd0, running}, 32'd0);
    check_eq("rst_alarm", {31'd0, alarm}, 32'd0);
    press(1'b0, 1'b0, 1'b1);
    check_eq("start0_run", {31'd0, running}, 32'd0);
    check_eq("start0_edit", {30'd0, edit_sel}, 32'd0);

    // Time entry 02:05.
    press(1'b1, 1'b0, 1'b0);
    check_eq("edit_min", {30'd0, edit_sel}, 32'd1);
    repeat (2) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check_eq("edit_sec", {30'd0, edit_sel}, 32'd2);
    repeat (5) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check_eq("edit_none", {30'd0, edit_sel}, 32'd0);
    check_time("entry", 8'h02, 8'h05);

    // Countdown 00:02 to alarm and auto-clear.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (2) press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check_eq("run_hi", {31'd0, running}, 32'd1);
    check_eq("run_edit", {30'd0, edit_sel}, 32'd0);
    wait_edges(9);
    check_time("pre_tick1", 8'h00, 8'h02);
    wait_edges(1);
    check_time("tick1", 8'h00, 8'h01);
    wait_edges(10);
    check_time("tick2", 8'h00, 8'h00);
    check_eq("alarm_hi", {31'd0, alarm}, 32'd1);
    check_eq("alarm_run", {31'd0, running}, 32'd0);
    wait_edges(29);
    check_eq("alarm_hold", {31'd0, alarm}, 32'd1);
    wait_edges(1);
    check_eq("alarm_clr", {31'd0, alarm}, 32'd0);

    // Minute borrow, pause on tick, resume and clear.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    wait_edges(10);
    check_time("borrow", 8'h00, 8'h59);
    wait_edges(9);
    press(1'b0, 1'b0, 1'b1);
    check_eq("pause_run", {31'd0, running}, 32'd0);
    check_time("pause_tick", 8'h00, 8'h59);
    wait_edges(15);
    check_time("pause_hold", 8'h00, 8'h59);
    press(1'b0, 1'b0, 1'b1);
    check_eq("resume_run", {31'd0, running}, 32'd1);
    wait_edges(9);
    check_time("resume_wait", 8'h00, 8'h59);
    wait_edges(1);
    check_time("resume_tick", 8'h00, 8'h58);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    check_time("pause_clr", 8'h00, 8'h00);
    press(1'b0, 1'b0, 1'b1);
    check_eq("clr_idle", {31'd0, running}, 32'd0);

    // Second wrap and start+inc priority.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (58) press(1'b0, 1'b1, 1'b0);
    check_time("sec58", 8'h00, 8'h58);
    press(1'b0, 1'b1, 1'b0);
    check_time("sec59", 8'h00, 8'h59);
    press(1'b0, 1'b1, 1'b0);
    check_time("sec_wrap", 8'h00, 8'h00);
    press(1'b0, 1'b1, 1'b0);
    check_time("sec01", 8'h00, 8'h01);
    press(1'b0, 1'b1, 1'b1);
    check_eq("prio_run", {31'd0, running}, 32'd1);
    check_time("prio_time", 8'h00, 8'h01);

    // Minute wrap and start from edit at 00:00.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    repeat (99) press(1'b0, 1'b1, 1'b0);
    check_time("min99", 8'h99, 8'h00);
    press(1'b0, 1'b1, 1'b0);
    check_time("min_wrap", 8'h00, 8'h00);
    press(1'b0, 1'b0, 1'b1);
    check_eq("edit0_sel", {30'd0, edit_sel}, 32'd0);
    check_eq("edit0_run", {31'd0, running}, 32'd0);

    // Held increment in EDIT_MIN, then reset mid-hold.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    inc_down = 1'b1; inc_state = 1'b1;
    wait_edges(1);
    inc_down = 1'b0;
    wait_edges(19);
    inc_state = 1'b0;
    wait_edges(1);
`ifdef KT_AUTOREPEAT_EN
    check_time("hold", 8'h04, 8'h00);
`else
    check_time("hold", 8'h01, 8'h00);
`endif
    inc_down = 1'b1; inc_state = 1'b1;
    wait_edges(1);
    inc_down = 1'b0;
    wait_edges(5);
    rst_n = 1'b0;
    #1;
    check_time("hold_rst", 8'h00, 8'h00);
    check_eq("hold_rst_sel", {30'd0, edit_sel}, 32'd0);
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(12);
    check_time("hold_after", 8'h00, 8'h00);
    check_eq("hold_after_sel", {30'd0, edit_sel}, 32'd0);
    inc_state = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
